extend_shift_unit: RTL and testbench
====================================

// Module: extend_shift_unit
// PURPOSE
//   Parametrised immediate-extension and shift unit for the datapath.
//   - Extends an IN_W-bit field to OUT_W bits: zero-extend, sign-extend, or upper placement (LUI).
//   - Then applies an optional SLL/SRL/SRA of 0..OUT_W-1 bits, STEP bits per clock.
//   - Sits between decode and the ALU/branch-target adder.
//   - Uses valid/ready handshakes on both sides, so a multi-cycle shift can stall the pipeline.
// PARAMETERS
//   IN_W     16  input field width; 1 <= IN_W <= OUT_W
//   OUT_W    32  output/datapath width; power of 2, >= 2
//   STEP     1   bits shifted per clock; 1 <= STEP <= OUT_W
//   SHAMT_W  is a localparam, not overridable; SHAMT_W = $clog2(OUT_W).
// PORTS
//   Clk       in   1        clock, rising edge
//   Reset     in   1        synchronous, active-high reset
//   InValid   in   1        request present
//   InReady   out  1        unit can accept a request
//   InData    in   IN_W     field to extend
//   Mode      in   2        00 zero-ext, 01 sign-ext, 10 upper (InData at [OUT_W-1 -: IN_W], low bits 0), 11 = 00
//   Op        in   2        00 none, 01 SLL, 10 SRL, 11 SRA
//   Shamt     in   SHAMT_W  shift amount; ignored when Op=00
//   OutValid  out  1        result present
//   OutReady  in   1        consumer accepts result
//   OutData   out  OUT_W    result
//   Busy      out  1        high in any state other than IDLE
// BEHAVIOUR
//   Clocking and reset
//   - One clock; reset is synchronous and active-high.
//   - Reset values: state=IDLE, InReady=1, OutValid=0, OutData=0, Busy=0.
//   - Reset asserted in any state aborts the operation; the in-flight result is discarded.
//   States: IDLE, SHIFT, HOLD. All outputs are decoded from registers.
//   - IDLE: InReady=1. Accept occurs on an edge where InValid&InReady=1.
//     - Acc <= extended InData; Rem <= (Op==00) ? 0 : Shamt; latch Op.
//     - Next state = (Rem==0) ? HOLD : SHIFT.
//   - SHIFT: InReady=0. Each edge: k=min(STEP,Rem); Acc shifted by k; Rem <= Rem-k.
//     - SLL/SRL fill with 0. SRA fills with Acc[OUT_W-1] as captured at accept.
//     - Goes to HOLD on the edge where Rem reaches 0.
//   - HOLD: OutValid=1, OutData=Acc.
//     - On an edge with OutReady=1: go to IDLE; OutValid=0 in the next cycle.
//     - OutData and OutValid stay stable while OutReady=0.
//   OutData
//   - Is the Acc register in every state; it is meaningful only when OutValid=1.
//   Latency and throughput
//   - With accept at edge t, OutValid rises after edge t+N, where N = ceil(Rem/STEP).
//   - N=0 for Op=00 or Shamt=0.
//   - There is no overlap between operations: a new accept is possible only from edge t+N+1 after the handshake.
//   Boundary conditions
//   - InValid while Busy is ignored; the producer must hold it.
//   - InData/Mode/Op/Shamt changes after accept have no effect.
//   - Shamt=OUT_W-1 is the maximum shift, giving N=ceil((OUT_W-1)/STEP).
//   - Mode=10 with IN_W=OUT_W is identical to zero-extend.
//   - All arithmetic is unsigned on Rem, with no wrap.
// TESTING
//   1 Mode=01 Op=00 InData=16'h8001 -> OutValid after accept edge+0 (N=0), OutData=32'hFFFF8001
//   2 Mode=00 Op=01 Shamt=2 InData=16'h8001 STEP=1 -> Busy 3 cycles, OutData=32'h00020004
//   3 Mode=01 InData=16'hF000 Shamt=4:
//     - Op=11 -> 32'hFFFFFF00
//     - Op=10 -> 32'h0FFFFF00
//   4 Mode=10 Op=00 InData=16'h1234 -> 32'h12340000
//   5 STEP=4, Op=01, Shamt=31, InData=1 -> OutValid after exactly 8 SHIFT edges, OutData=32'h80000000
//   6 Backpressure and mid-operation reset:
//     - OutReady=0 for 5 cycles in HOLD -> OutData held, InReady=0, a second InValid is ignored;
//       OutReady=1 -> IDLE next cycle.
//     - Reset in SHIFT -> next cycle Busy=0, OutValid=0, OutData=0.

Source files
------------

// File: rtl/extend_shift_unit.sv
// Immediate extension (zero/sign/upper) followed by an optional multi-cycle SLL/SRL/SRA.
// Shifts STEP bits per clock, with valid/ready handshakes on both the request and result sides.
module extend_shift_unit #(
  parameter  int IN_W    = 16,
  parameter  int OUT_W   = 32,
  parameter  int STEP    = 1,
  localparam int SHAMT_W = $clog2(OUT_W)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [IN_W-1:0]    InData,
  input  logic [1:0]         Mode,
  input  logic [1:0]         Op,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [OUT_W-1:0]   OutData,
  output logic               Busy
);

  // state | meaning
  // IDLE  | waiting for a request, InReady=1
  // SHIFT | shifting acc by min(STEP, rem) each clock
  // HOLD  | result presented, waiting for OutReady
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int KW = SHAMT_W + 1;

  state_t             state;
  logic [OUT_W-1:0]   acc;
  logic [SHAMT_W-1:0] rem;
  logic [1:0]         op_q;
  logic               sign_q;

  logic [OUT_W-1:0]   ext;
  logic [KW-1:0]      rem_ext;
  logic [KW-1:0]      step_k;
  logic [SHAMT_W-1:0] rem_nxt;
  logic [OUT_W-1:0]   acc_shr;
  logic [OUT_W-1:0]   acc_nxt;

  always_comb begin
    ext = '0;
    case (Mode)
      2'b01:   ext = OUT_W'($signed(InData));
      2'b10:   ext = OUT_W'(InData) << (OUT_W - IN_W);
      default: ext = OUT_W'(InData);
    endcase
  end

  // k = min(STEP, rem); one extra bit because STEP may equal OUT_W
  always_comb begin
    rem_ext = {1'b0, rem};
    step_k  = (KW'(STEP) < rem_ext) ? KW'(STEP) : rem_ext;
    rem_nxt = rem - step_k[SHAMT_W-1:0];
    acc_shr = acc >> step_k;
    acc_nxt = acc;
    case (op_q)
      2'b01:   acc_nxt = acc << step_k;
      2'b10:   acc_nxt = acc_shr;
      2'b11:   acc_nxt = acc_shr | (sign_q ? ~({OUT_W{1'b1}} >> step_k) : '0);
      default: acc_nxt = acc;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      acc      <= '0;
      rem      <= '0;
      op_q     <= 2'b00;
      sign_q   <= 1'b0;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            acc     <= ext;
            op_q    <= Op;
            sign_q  <= ext[OUT_W-1];
            rem     <= (Op == 2'b00) ? '0 : Shamt;
            InReady <= 1'b0;
            Busy    <= 1'b1;
            if (Op == 2'b00 || Shamt == '0) begin
              state    <= HOLD;
              OutValid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          if (rem_nxt == '0) begin
            state    <= HOLD;
            OutValid <= 1'b1;
          end
        end
        HOLD: begin
          if (OutReady) begin
            state    <= IDLE;
            OutValid <= 1'b0;
            InReady  <= 1'b1;
            Busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          OutValid <= 1'b0;
          InReady  <= 1'b1;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

  assign OutData = acc;

endmodule

// File: tb/tb_extend_shift_unit.sv
// Bench for extend_shift_unit: two instances (STEP=1 and STEP=4), directed cases plus random
// requests checked against an arithmetic model of extension, shift result and latency.
module tb_extend_shift_unit;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic        clk;
  logic        reset;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] in_data   [2];
  logic [1:0]  mode      [2];
  logic [1:0]  op        [2];
  logic [4:0]  shamt     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic        busy      [2];

  int n_cmp = 0;
  int n_err = 0;
  int steps [2] = '{1, 4};

  extend_shift_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .STEP(1)) u_dut1 (
    .Clk(clk), .Reset(reset),
    .InValid(in_valid[0]), .InReady(in_ready[0]), .InData(in_data[0]),
    .Mode(mode[0]), .Op(op[0]), .Shamt(shamt[0]),
    .OutValid(out_valid[0]), .OutReady(out_ready[0]), .OutData(out_data[0]), .Busy(busy[0])
  );

  extend_shift_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .STEP(4)) u_dut4 (
    .Clk(clk), .Reset(reset),
    .InValid(in_valid[1]), .InReady(in_ready[1]), .InData(in_data[1]),
    .Mode(mode[1]), .Op(op[1]), .Shamt(shamt[1]),
    .OutValid(out_valid[1]), .OutReady(out_ready[1]), .OutData(out_data[1]), .Busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [15:0] d, input logic [1:0] md,
                                               input logic [1:0] o, input int sh);
    logic [31:0]        ext;
    logic signed [31:0] s;
    case (md)
      2'b01:   ext = {{16{d[15]}}, d};
      2'b10:   ext = {d, 16'h0000};
      default: ext = {16'h0000, d};
    endcase
    s = ext;
    case (o)
      2'b01:   return ext << sh;
      2'b10:   return ext >> sh;
      2'b11:   return s >>> sh;
      default: return ext;
    endcase
  endfunction

  function automatic int model_latency(input int idx, input logic [1:0] o, input int sh);
    if (o == 2'b00) return 0;
    return (sh + steps[idx] - 1) / steps[idx];
  endfunction

  // Runs one request end to end on instance idx; inputs change 1 time unit after a rising edge.
  task automatic run_op(input int idx, input logic [15:0] d, input logic [1:0] md,
                        input logic [1:0] o, input int sh, input int hold_cycles);
    logic [31:0] exp_data;
    int          exp_n;
    int          cnt;
    exp_data = model_result(d, md, o, sh);
    exp_n    = model_latency(idx, o, sh);
    cnt = 0;
    while (!in_ready[idx] && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("ready_before_req", 32'(in_ready[idx]), 32'd1);
    in_valid[idx] = 1'b1;
    in_data[idx]  = d;
    mode[idx]     = md;
    op[idx]       = o;
    shamt[idx]    = 5'(sh);
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    in_data[idx]  = 16'($urandom);
    mode[idx]     = 2'($urandom);
    op[idx]       = 2'($urandom);
    shamt[idx]    = 5'($urandom);
    chk("busy_after_accept", 32'(busy[idx]), 32'd1);
    chk("inready_after_accept", 32'(in_ready[idx]), 32'd0);
    cnt = 0;
    while (!out_valid[idx] && cnt < 100) begin
      chk("busy_in_shift", 32'(busy[idx]), 32'd1);
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(exp_n));
    chk("out_valid", 32'(out_valid[idx]), 32'd1);
    chk("out_data", out_data[idx], exp_data);
    for (int i = 0; i < hold_cycles; i++) begin
      in_valid[idx] = 1'b1;
      in_data[idx]  = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_data", out_data[idx], exp_data);
      chk("hold_valid", 32'(out_valid[idx]), 32'd1);
      chk("hold_inready", 32'(in_ready[idx]), 32'd0);
    end
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
    in_valid[idx]  = 1'b0;
    chk("release_valid", 32'(out_valid[idx]), 32'd0);
    chk("release_inready", 32'(in_ready[idx]), 32'd1);
    chk("release_busy", 32'(busy[idx]), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      mode[i]      = '0;
      op[i]        = '0;
      shamt[i]     = '0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_inready", 32'(in_ready[i]), 32'd1);
      chk("rst_outvalid", 32'(out_valid[i]), 32'd0);
      chk("rst_outdata", out_data[i], 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(0, 16'h8001, 2'b01, 2'b00, 0, 0);
    chk("t1_value", model_result(16'h8001, 2'b01, 2'b00, 0), 32'hFFFF8001);
    run_op(0, 16'h8001, 2'b00, 2'b01, 2, 0);
    run_op(0, 16'hF000, 2'b01, 2'b11, 4, 0);
    run_op(0, 16'hF000, 2'b01, 2'b10, 4, 1);
    run_op(0, 16'h1234, 2'b10, 2'b00, 0, 0);
    run_op(0, 16'h1234, 2'b11, 2'b00, 0, 0);
    run_op(1, 16'h0001, 2'b00, 2'b01, 31, 0);
    run_op(1, 16'h8000, 2'b01, 2'b11, 31, 0);
    run_op(0, 16'hA5A5, 2'b00, 2'b01, 31, 0);
    run_op(0, 16'h00FF, 2'b00, 2'b01, 0, 5);

    // abort a long shift with reset
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h00FF;
    mode[0]     = 2'b00;
    op[0]       = 2'b01;
    shamt[0]    = 5'd20;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_outvalid", 32'(out_valid[0]), 32'd0);
    chk("abort_outdata", out_data[0], 32'd0);
    chk("abort_inready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      run_op(n % 2, 16'($urandom), 2'($urandom), 2'($urandom),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
